// File: rtl/snoop_bus_ctrl.sv
// Snooping bus controller for a two-core system. One miss transaction is
// served at a time: the peer core is snooped, then the block is either pulled
// from a peer holding it Modified (with a write-back to memory) or fetched from
// memory, and finally the requester is told the miss is complete.
module snoop_bus_ctrl #(
   parameter int SNOOP_CYC = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  read_miss,
   input  logic [1:0]  write_miss,
   input  logic [10:0] miss_addr0,
   input  logic [10:0] miss_addr1,
   input  logic [1:0]  block_state0,
   input  logic [1:0]  block_state1,
   input  logic [1:0]  cpu_search_found,
   input  logic        mem_rdy,
   output logic [1:0]  cpu_search,
   output logic [10:0] bus_addr_out,
   output logic [1:0]  cpu_datasel,
   output logic [1:0]  invalidate,
   output logic [1:0]  miss_done,
   output logic        mem_re,
   output logic        mem_we,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE,
      SNOOP,
      XFER,
      FETCH,
      DONE
   } state_t;

   localparam logic [2:0] CNT_LAST = 3'(SNOOP_CYC - 1);
   localparam logic [1:0] ST_MODIFIED = 2'b10;

   state_t      state, state_next;
   logic        req_core, req_core_next;
   logic        req_write, req_write_next;
   logic        peer_found, peer_found_next;
   logic        last_grant, last_grant_next;
   logic [2:0]  snoop_cnt, snoop_cnt_next;
   logic [10:0] addr_next;
   logic [1:0]  cpu_search_next, cpu_datasel_next, invalidate_next, miss_done_next;
   logic        mem_re_next, mem_we_next, busy_next;

   logic [1:0]  req;
   logic        grant;
   logic [1:0]  peer_mask, req_mask;
   logic        found_peer;
   logic [1:0]  state_peer;

   // Peer-relative views of the latched requester, used by every busy state.
   always_comb begin
      peer_mask  = req_core ? 2'b01 : 2'b10;
      req_mask   = req_core ? 2'b10 : 2'b01;
      found_peer = req_core ? cpu_search_found[0] : cpu_search_found[1];
      state_peer = req_core ? block_state0 : block_state1;
      req        = read_miss | write_miss;
      grant      = (req == 2'b11) ? ~last_grant : req[1];
   end

   // Next-state and next-output decode; outputs are registered from these values.
   always_comb begin
      state_next       = state;
      req_core_next    = req_core;
      req_write_next   = req_write;
      peer_found_next  = peer_found;
      last_grant_next  = last_grant;
      snoop_cnt_next   = snoop_cnt;
      addr_next        = bus_addr_out;
      cpu_search_next  = 2'b00;
      cpu_datasel_next = 2'b00;
      invalidate_next  = 2'b00;
      miss_done_next   = 2'b00;
      mem_re_next      = 1'b0;
      mem_we_next      = 1'b0;

      case (state)
         IDLE: begin
            if (req != 2'b00) begin
               req_core_next   = grant;
               last_grant_next = grant;
               req_write_next  = grant ? write_miss[1] : write_miss[0];
               addr_next       = grant ? miss_addr1 : miss_addr0;
               peer_found_next = 1'b0;
               snoop_cnt_next  = 3'd0;
               cpu_search_next = grant ? 2'b01 : 2'b10;
               state_next      = SNOOP;
            end
         end
         SNOOP: begin
            if (snoop_cnt == CNT_LAST) begin
               peer_found_next = found_peer;
               if (found_peer && (state_peer == ST_MODIFIED)) begin
                  cpu_datasel_next = peer_mask;
                  mem_we_next      = 1'b1;
                  state_next       = XFER;
               end else begin
                  mem_re_next = 1'b1;
                  state_next  = FETCH;
               end
            end else begin
               snoop_cnt_next  = snoop_cnt + 3'd1;
               cpu_search_next = peer_mask;
            end
         end
         XFER, FETCH: begin
            if (mem_rdy) begin
               miss_done_next  = req_mask;
               invalidate_next = (req_write && peer_found) ? peer_mask : 2'b00;
               state_next      = DONE;
            end else if (state == XFER) begin
               cpu_datasel_next = peer_mask;
               mem_we_next      = 1'b1;
            end else begin
               mem_re_next = 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

   // State, transaction context and registered outputs; reset abandons any transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         req_core     <= 1'b0;
         req_write    <= 1'b0;
         peer_found   <= 1'b0;
         last_grant   <= 1'b1;
         snoop_cnt    <= 3'd0;
         bus_addr_out <= 11'd0;
         cpu_search   <= 2'b00;
         cpu_datasel  <= 2'b00;
         invalidate   <= 2'b00;
         miss_done    <= 2'b00;
         mem_re       <= 1'b0;
         mem_we       <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_next;
         req_core     <= req_core_next;
         req_write    <= req_write_next;
         peer_found   <= peer_found_next;
         last_grant   <= last_grant_next;
         snoop_cnt    <= snoop_cnt_next;
         bus_addr_out <= addr_next;
         cpu_search   <= cpu_search_next;
         cpu_datasel  <= cpu_datasel_next;
         invalidate   <= invalidate_next;
         miss_done    <= miss_done_next;
         mem_re       <= mem_re_next;
         mem_we       <= mem_we_next;
         busy         <= busy_next;
      end
   end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Testbench for snoop_bus_ctrl. Two instances share the stimulus: one with the
// default snoop length and one with a three-cycle snoop. Each transaction is
// predicted from the bus protocol rules (arbitration, snoop window, path choice,
// completion pulses) and compared cycle by cycle.
module tb_snoop_bus_ctrl;

   logic        clk;
   logic        rst;
   logic [1:0]  read_miss, write_miss;
   logic [10:0] miss_addr0, miss_addr1;
   logic [1:0]  block_state0, block_state1;
   logic [1:0]  cpu_search_found;
   logic        mem_rdy;

   logic [1:0]  cs  [2];
   logic [1:0]  ds  [2];
   logic [1:0]  inv [2];
   logic [1:0]  md  [2];
   logic [10:0] ba  [2];
   logic        re  [2];
   logic        we  [2];
   logic        bz  [2];

   int n_checks = 0;
   int n_fail   = 0;
   int last_g   = 1;

   snoop_bus_ctrl #(.SNOOP_CYC(1)) dut (
      .clk(clk), .rst(rst), .read_miss(read_miss), .write_miss(write_miss),
      .miss_addr0(miss_addr0), .miss_addr1(miss_addr1),
      .block_state0(block_state0), .block_state1(block_state1),
      .cpu_search_found(cpu_search_found), .mem_rdy(mem_rdy),
      .cpu_search(cs[0]), .bus_addr_out(ba[0]), .cpu_datasel(ds[0]),
      .invalidate(inv[0]), .miss_done(md[0]), .mem_re(re[0]), .mem_we(we[0]),
      .busy(bz[0])
   );

   snoop_bus_ctrl #(.SNOOP_CYC(3)) dut3 (
      .clk(clk), .rst(rst), .read_miss(read_miss), .write_miss(write_miss),
      .miss_addr0(miss_addr0), .miss_addr1(miss_addr1),
      .block_state0(block_state0), .block_state1(block_state1),
      .cpu_search_found(cpu_search_found), .mem_rdy(mem_rdy),
      .cpu_search(cs[1]), .bus_addr_out(ba[1]), .cpu_datasel(ds[1]),
      .invalidate(inv[1]), .miss_done(md[1]), .mem_re(re[1]), .mem_we(we[1]),
      .busy(bz[1])
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      read_miss        = 2'b00;
      write_miss       = 2'b00;
      miss_addr0       = 11'd0;
      miss_addr1       = 11'd0;
      block_state0     = 2'b00;
      block_state1     = 2'b00;
      cpu_search_found = 2'b00;
      mem_rdy          = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
      last_g = 1;
   endtask

   // Drive random peer responses, leaving the peer bit of core (1-g) forced when asked.
   task automatic scramble_peer(input int g, input bit force_it, input logic fnd, input logic [1:0] pst);
      logic [1:0] f;
      logic [1:0] s0, s1;
      f  = 2'($urandom);
      s0 = 2'($urandom);
      s1 = 2'($urandom);
      if (force_it) begin
         f[1-g] = fnd;
         if (g == 0) s1 = pst;
         else        s0 = pst;
      end
      cpu_search_found = f;
      block_state0     = s0;
      block_state1     = s1;
   endtask

   // Serve one pending request from an IDLE cycle and check every cycle of it.
   task automatic serve_one(input int d, input int cyc, input logic fnd, input logic [1:0] pst,
                            input int lat, input bit quiet);
      logic [1:0]  rq, gmask, pmask;
      logic [10:0] addr, a0, a1;
      logic [10:0] exp_v, got_v;
      logic        wr, m;
      int          g;
      rq    = read_miss | write_miss;
      g     = (rq == 2'b11) ? (1 - last_g) : (rq[0] ? 0 : 1);
      wr    = write_miss[g];
      a0    = miss_addr0;
      a1    = miss_addr1;
      addr  = (g == 1) ? a1 : a0;
      gmask = 2'b01 << g;
      pmask = 2'b01 << (1 - g);
      m     = fnd && (pst == 2'b10);

      for (int k = 0; k < cyc; k++) begin
         tick();
         exp_v = {pmask, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
         got_v = {cs[d], ds[d], inv[d], md[d], re[d], we[d], bz[d]};
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL snoop_outputs dut%0d cycle %0d: got %b expected %b", d, k, got_v, exp_v);
         end
         n_checks++;
         if (ba[d] !== addr) begin
            n_fail++;
            $display("[TB] FAIL snoop_addr dut%0d: got %h expected %h", d, ba[d], addr);
         end
         miss_addr0 = 11'($urandom);
         miss_addr1 = 11'($urandom);
         mem_rdy    = 1'($urandom);
         if (k == cyc - 1) scramble_peer(g, 1'b1, fnd, pst);
         else if (quiet)   scramble_peer(g, 1'b1, 1'b0, 2'b00);
         else              scramble_peer(g, 1'b0, 1'b0, 2'b00);
      end

      for (int j = 0; j <= lat; j++) begin
         tick();
         exp_v = {2'b00, (m ? pmask : 2'b00), 2'b00, 2'b00, ~m, m, 1'b1};
         got_v = {cs[d], ds[d], inv[d], md[d], re[d], we[d], bz[d]};
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL mem_phase dut%0d cycle %0d: got %b expected %b", d, j, got_v, exp_v);
         end
         n_checks++;
         if (ba[d] !== addr) begin
            n_fail++;
            $display("[TB] FAIL mem_addr dut%0d: got %h expected %h", d, ba[d], addr);
         end
         mem_rdy = (j == lat);
         scramble_peer(g, 1'b0, 1'b0, 2'b00);
      end

      tick();
      exp_v = {2'b00, 2'b00, ((wr && fnd) ? pmask : 2'b00), gmask, 1'b0, 1'b0, 1'b1};
      got_v = {cs[d], ds[d], inv[d], md[d], re[d], we[d], bz[d]};
      n_checks++;
      if (got_v !== exp_v) begin
         n_fail++;
         $display("[TB] FAIL done_outputs dut%0d: got %b expected %b", d, got_v, exp_v);
      end
      n_checks++;
      if (ba[d] !== addr) begin
         n_fail++;
         $display("[TB] FAIL done_addr dut%0d: got %h expected %h", d, ba[d], addr);
      end
      read_miss[g]  = 1'b0;
      write_miss[g] = 1'b0;
      miss_addr0    = a0;
      miss_addr1    = a1;
      mem_rdy       = 1'b0;
      last_g        = g;

      tick();
      got_v = {cs[d], ds[d], inv[d], md[d], re[d], we[d], bz[d]};
      n_checks++;
      if (got_v !== 11'd0) begin
         n_fail++;
         $display("[TB] FAIL idle_outputs dut%0d: got %b expected 0", d, got_v);
      end
      n_checks++;
      if (ba[d] !== addr) begin
         n_fail++;
         $display("[TB] FAIL idle_addr_hold dut%0d: got %h expected %h", d, ba[d], addr);
      end
   endtask

   // Outputs are all zero while reset is held.
   task automatic test_reset;
      rst = 1'b1;
      clear_inputs();
      #3;
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if ({cs[d], ds[d], inv[d], md[d], re[d], we[d], bz[d], ba[d]} !== 22'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state dut%0d: got %b expected 0", d,
                     {cs[d], ds[d], inv[d], md[d], re[d], we[d], bz[d], ba[d]});
         end
      end
      tick();
      rst = 1'b0;
      last_g = 1;
      tick();
   endtask

   // Core 0 read miss, peer misses, memory answers on the third cycle.
   task automatic test_read_fetch;
      read_miss  = 2'b01;
      miss_addr0 = 11'h123;
      serve_one(0, 1, 1'b0, 2'b00, 2, 1'b0);
   endtask

   // Core 1 write miss, peer holds it Modified, memory answers at once.
   task automatic test_write_xfer;
      write_miss = 2'b10;
      miss_addr1 = 11'h7FF;
      serve_one(0, 1, 1'b1, 2'b10, 0, 1'b0);
   endtask

   // Peer has the block Shared: memory fill, no data transfer, no invalidate.
   task automatic test_shared;
      read_miss  = 2'b01;
      miss_addr0 = 11'h2A5;
      serve_one(0, 1, 1'b1, 2'b01, 1, 1'b0);
   endtask

   // Simultaneous requests after reset, then an immediate repeat of both.
   task automatic test_back_to_back;
      do_reset();
      read_miss  = 2'b11;
      miss_addr0 = 11'h011;
      miss_addr1 = 11'h622;
      serve_one(0, 1, 1'b0, 2'b00, 0, 1'b0);
      read_miss[0] = 1'b1;
      serve_one(0, 1, 1'b1, 2'b10, 1, 1'b0);
      serve_one(0, 1, 1'b0, 2'b11, 0, 1'b0);
   endtask

   // Reset in the middle of a memory fill abandons the transaction.
   task automatic test_reset_mid;
      logic [21:0] got_v;
      read_miss  = 2'b01;
      miss_addr0 = 11'h345;
      tick();
      cpu_search_found = 2'b00;
      tick();
      n_checks++;
      if (re[0] !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL fetch_entry: got mem_re=%b expected 1", re[0]);
      end
      #2;
      rst = 1'b1;
      #1;
      got_v = {cs[0], ds[0], inv[0], md[0], re[0], we[0], bz[0], ba[0]};
      n_checks++;
      if (got_v !== 22'd0) begin
         n_fail++;
         $display("[TB] FAIL async_reset: got %b expected 0", got_v);
      end
      clear_inputs();
      mem_rdy = 1'b1;
      tick();
      rst = 1'b0;
      last_g = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if ({md[0], bz[0]} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL no_done_after_reset: got %b expected 000", {md[0], bz[0]});
         end
      end
      mem_rdy    = 1'b0;
      write_miss = 2'b10;
      miss_addr1 = 11'h0F0;
      serve_one(0, 1, 1'b1, 2'b01, 1, 1'b0);
   endtask

   // Three-cycle snoop where the match is only reported in the final cycle.
   task automatic test_snoop3;
      do_reset();
      write_miss = 2'b01;
      miss_addr0 = 11'h456;
      serve_one(1, 3, 1'b1, 2'b10, 0, 1'b1);
   endtask

   // Random request patterns, peer responses and memory latencies.
   task automatic test_random(input int d, input int cyc, input int n);
      logic [1:0] r;
      for (int t = 0; t < n; t++) begin
         r          = 2'($urandom_range(1, 3));
         write_miss = r & 2'($urandom);
         read_miss  = r & ~(write_miss & 2'($urandom));
         miss_addr0 = 11'($urandom);
         miss_addr1 = 11'($urandom);
         for (int s = 0; s < 2 && (read_miss | write_miss) != 2'b00; s++)
            serve_one(d, cyc, 1'($urandom), 2'($urandom), $urandom_range(0, 4), 1'b0);
      end
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      test_read_fetch();
      test_write_xfer();
      test_shared();
      test_back_to_back();
      test_reset_mid();
      test_random(0, 1, 25);
      test_snoop3();
      test_random(1, 3, 15);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
